head_table: RTL

Bucket-head lookup stage in front of `data_table`. It accepts hashed requests, reads the head-pointer RAM at the request's bucket, and forwards each request with `head_ptr`/`head_ptr_val` attached. It takes head-pointer updates back from `data_table` when inserts or deletes change a chain's first entry. It also owns the bucket RAM's clear sequence.

---
 rtl/head_table.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/head_table.sv
// Bucket-head lookup stage: reads the head-pointer RAM for each request, forwards it with the head
// attached, absorbs head updates from data_table and runs the RAM clear. Optional counters: HEAD_TABLE_STATS_EN.
module head_table #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int CMD_WIDTH      = 2,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [KEY_WIDTH-1:0]      in_key_i,
    input  logic [VALUE_WIDTH-1:0]    in_value_i,
    input  logic [CMD_WIDTH-1:0]      in_cmd_i,
    input  logic [BUCKET_WIDTH-1:0]   in_bucket_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [KEY_WIDTH-1:0]      out_key_o,
    output logic [VALUE_WIDTH-1:0]    out_value_o,
    output logic [CMD_WIDTH-1:0]      out_cmd_o,
    output logic [BUCKET_WIDTH-1:0]   out_bucket_o,
    output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr_o,
    output logic                      out_head_ptr_val_o,
    input  logic                      upd_wr_i,
    input  logic [BUCKET_WIDTH-1:0]   upd_bucket_i,
    input  logic [HEAD_PTR_WIDTH-1:0] upd_ptr_i,
    input  logic                      upd_ptr_val_i,
    input  logic                      clear_ram_run_i,
    output logic                      clear_ram_done_o
`ifdef HEAD_TABLE_STATS_EN
    ,
    output logic [31:0]               stat_lookup_cnt_o,
    output logic [31:0]               stat_empty_hit_cnt_o
`endif
);

    localparam int DEPTH       = 1 << BUCKET_WIDTH;
    localparam int ENTRY_WIDTH = HEAD_PTR_WIDTH + 1;

    logic [ENTRY_WIDTH-1:0]    r_mem [DEPTH];
    logic [ENTRY_WIDTH-1:0]    r_q_a;

    logic                      r_out_valid;
    logic [KEY_WIDTH-1:0]      r_key;
    logic [VALUE_WIDTH-1:0]    r_value;
    logic [CMD_WIDTH-1:0]      r_cmd;
    logic [BUCKET_WIDTH-1:0]   r_bucket;

    logic                      r_byp_flag;
    logic [HEAD_PTR_WIDTH-1:0] r_byp_ptr;
    logic                      r_byp_val;

    logic                      r_clear_flag;
    logic [BUCKET_WIDTH-1:0]   r_clear_addr;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_out_hs;
    logic                      w_clear_last;
    logic                      w_upd_en;
    logic                      w_upd_hit_in;
    logic                      w_upd_hit_out;
    logic                      w_re_a;
    logic [BUCKET_WIDTH-1:0]   w_addr_a;
    logic                      w_we_b;
    logic [BUCKET_WIDTH-1:0]   w_addr_b;
    logic [ENTRY_WIDTH-1:0]    w_din_b;

    // Handshake, clear-end and update-match decode
    always_comb begin
        w_in_ready    = !r_clear_flag && (!r_out_valid || out_ready_i);
        w_accept      = in_valid_i && w_in_ready;
        w_out_hs      = r_out_valid && out_ready_i;
        w_clear_last  = r_clear_flag && (r_clear_addr == {BUCKET_WIDTH{1'b1}});
        w_upd_en      = upd_wr_i && !r_clear_flag;
        w_upd_hit_in  = w_upd_en && w_accept && (upd_bucket_i == in_bucket_i);
        w_upd_hit_out = w_upd_en && r_out_valid && (upd_bucket_i == r_bucket);
        w_re_a        = w_accept;
        if (w_accept) begin
            w_addr_a = in_bucket_i;
        end else begin
            w_addr_a = r_bucket;
        end
    end

    // Port B source select: the clear sweep owns the write port while it runs
    always_comb begin
        w_we_b   = 1'b0;
        w_addr_b = upd_bucket_i;
        w_din_b  = {upd_ptr_i, upd_ptr_val_i};
        if (r_clear_flag) begin
            w_we_b   = 1'b1;
            w_addr_b = r_clear_addr;
            w_din_b  = {ENTRY_WIDTH{1'b0}};
        end else if (upd_wr_i) begin
            w_we_b   = 1'b1;
        end else begin
            w_we_b   = 1'b0;
        end
    end

    // Head RAM write port (contents intentionally not reset)
    always_ff @(posedge clk_i) begin
        if (w_we_b) begin
            r_mem[w_addr_b] <= w_din_b;
        end
    end

    // Head RAM read port: loads only on accept so a pending output keeps its pre-clear head
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q_a <= {ENTRY_WIDTH{1'b0}};
        end else if (w_re_a) begin
            r_q_a <= r_mem[w_addr_a];
        end
    end

    // Output stage: valid flag and payload capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_key       <= {KEY_WIDTH{1'b0}};
            r_value     <= {VALUE_WIDTH{1'b0}};
            r_cmd       <= {CMD_WIDTH{1'b0}};
            r_bucket    <= {BUCKET_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_key       <= in_key_i;
            r_value     <= in_value_i;
            r_cmd       <= in_cmd_i;
            r_bucket    <= in_bucket_i;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Bypass register: an update racing the RAM read, or landing on a stalled output, overrides q_a
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_byp_flag <= 1'b0;
            r_byp_ptr  <= {HEAD_PTR_WIDTH{1'b0}};
            r_byp_val  <= 1'b0;
        end else if (w_accept) begin
            r_byp_flag <= w_upd_hit_in;
            if (w_upd_hit_in) begin
                r_byp_ptr <= upd_ptr_i;
                r_byp_val <= upd_ptr_val_i;
            end
        end else if (w_out_hs) begin
            r_byp_flag <= 1'b0;
        end else if (w_upd_hit_out) begin
            r_byp_flag <= 1'b1;
            r_byp_ptr  <= upd_ptr_i;
            r_byp_val  <= upd_ptr_val_i;
        end
    end

    // Clear sequencer: a run request (even mid-sweep) restarts at address 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clear_flag <= 1'b0;
            r_clear_addr <= {BUCKET_WIDTH{1'b0}};
        end else if (clear_ram_run_i) begin
            r_clear_flag <= 1'b1;
            r_clear_addr <= {BUCKET_WIDTH{1'b0}};
        end else if (r_clear_flag) begin
            r_clear_addr <= r_clear_addr + BUCKET_WIDTH'(1);
            if (w_clear_last) begin
                r_clear_flag <= 1'b0;
            end
        end
    end

    // Head field select
    always_comb begin
        if (r_byp_flag) begin
            out_head_ptr_o     = r_byp_ptr;
            out_head_ptr_val_o = r_byp_val;
        end else begin
            out_head_ptr_o     = r_q_a[ENTRY_WIDTH-1:1];
            out_head_ptr_val_o = r_q_a[0];
        end
    end

    assign in_ready_o       = w_in_ready;
    assign out_valid_o      = r_out_valid;
    assign out_key_o        = r_key;
    assign out_value_o      = r_value;
    assign out_cmd_o        = r_cmd;
    assign out_bucket_o     = r_bucket;
    assign clear_ram_done_o = w_clear_last;

`ifdef HEAD_TABLE_STATS_EN
    logic [31:0] r_stat_lookup;
    logic [31:0] r_stat_empty;

    // Saturating lookup / empty-bucket counters, cleared with the RAM
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_ram_run_i) begin
            r_stat_lookup <= 32'h0000_0000;
            r_stat_empty  <= 32'h0000_0000;
        end else if (w_out_hs) begin
            if (r_stat_lookup != 32'hFFFF_FFFF) begin
                r_stat_lookup <= r_stat_lookup + 32'h0000_0001;
            end
            if (!out_head_ptr_val_o && (r_stat_empty != 32'hFFFF_FFFF)) begin
                r_stat_empty <= r_stat_empty + 32'h0000_0001;
            end
        end
    end

    assign stat_lookup_cnt_o    = r_stat_lookup;
    assign stat_empty_hit_cnt_o = r_stat_empty;
`endif

endmodule
